// File: rtl/surf_dout_framer.sv
// rtl/surf_dout_framer.sv - SURF DOUT byte stream to 32-bit framed stream packer
module surf_dout_framer #(
  parameter int         FRAME_BYTES = 8,
  parameter logic [7:0] SOF_BYTE    = 8'hA5,
  parameter int         FIFO_DEPTH  = 16,
  parameter int         ERRCNT_BITS = 16
) (
  input  logic                   sysclk_i,
  input  logic                   rst_n_i,
  input  logic [7:0]             dout_i,
  input  logic                   dout_valid_i,
  input  logic                   dout_biterr_i,
  output logic [31:0]            m_axis_tdata_o,
  output logic                   m_axis_tvalid_o,
  input  logic                   m_axis_tready_i,
  output logic                   m_axis_tlast_o,
  output logic [15:0]            frame_count_o,
  output logic                   overflow_o,
  input  logic                   overflow_clr_i,
  output logic [ERRCNT_BITS-1:0] biterr_count_o,
  input  logic                   biterr_clr_i
);

  localparam int CW = $clog2(FRAME_BYTES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_BYTES - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   WORDS_W  = (AW + 1)'(FRAME_BYTES / 4);

  typedef enum logic [1:0] {S_HUNT, S_COLLECT, S_DROP} state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]          r_bytecnt;
  logic [23:0]            r_pack;
  logic [32:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_mem_cnt;
  logic [AW:0]            r_occ;
  logic [31:0]            r_tdata;
  logic                   r_tlast;
  logic                   r_tvalid;
  logic [15:0]            r_frame_cnt;
  logic                   r_ovf;
  logic [ERRCNT_BITS-1:0] r_biterr;

  logic w_is_last;
  logic w_room;
  logic w_count_en;
  logic w_push;
  logic w_frame_done;
  logic w_drop_set;
  logic w_pop;
  logic w_load;

  assign w_is_last = (r_bytecnt == LAST_IDX);
  // Occupancy includes the output register, so a whole frame must fit in what is left.
  assign w_room    = ((DEPTH_W - r_occ) >= WORDS_W);
  assign w_pop     = r_tvalid && m_axis_tready_i;
  assign w_load    = (r_mem_cnt != '0) && (!r_tvalid || w_pop);

  // State register.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) r_state <= S_HUNT;
    else          r_state <= w_next;
  end

  // Next-state decode plus the per-byte strobes that drive the datapath.
  always_comb begin
    w_next       = r_state;
    w_count_en   = 1'b0;
    w_push       = 1'b0;
    w_frame_done = 1'b0;
    w_drop_set   = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (dout_valid_i && (dout_i == SOF_BYTE)) begin
          if (w_room) begin
            w_next = S_COLLECT;
          end else begin
            w_next     = S_DROP;
            w_drop_set = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (dout_valid_i) begin
          w_count_en = 1'b1;
          if (r_bytecnt[1:0] == 2'd3) w_push = 1'b1;
          if (w_is_last) begin
            w_frame_done = 1'b1;
            w_next       = S_HUNT;
          end
        end
      end
      S_DROP: begin
        if (dout_valid_i) begin
          w_count_en = 1'b1;
          if (w_is_last) w_next = S_HUNT;
        end
      end
      default: w_next = S_HUNT;
    endcase
  end

  // Payload byte index; wraps to zero on the last byte so HUNT always starts clean.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i)        r_bytecnt <= '0;
    else if (w_count_en) r_bytecnt <= w_is_last ? '0 : r_bytecnt + CW'(1);
  end

  // Lanes 0..2 are held here; lane 3 goes straight from dout_i into the FIFO.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      r_pack <= '0;
    end else if (r_state == S_COLLECT && dout_valid_i) begin
      case (r_bytecnt[1:0])
        2'd0:    r_pack[7:0]   <= dout_i;
        2'd1:    r_pack[15:8]  <= dout_i;
        2'd2:    r_pack[23:16] <= dout_i;
        default: r_pack        <= r_pack;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge sysclk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_is_last, dout_i, r_pack};
  end

  // FIFO pointers, storage count and total occupancy (storage + output register).
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_occ     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_load})
        2'b10:   r_mem_cnt <= r_mem_cnt + (AW + 1)'(1);
        2'b01:   r_mem_cnt <= r_mem_cnt - (AW + 1)'(1);
        default: r_mem_cnt <= r_mem_cnt;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (AW + 1)'(1);
        2'b01:   r_occ <= r_occ - (AW + 1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Registered output stage; data only moves when the slot is empty or being taken.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (w_load) begin
      r_tdata  <= r_mem[r_rd_ptr][31:0];
      r_tlast  <= r_mem[r_rd_ptr][32];
      r_tvalid <= 1'b1;
    end else if (w_pop) begin
      r_tvalid <= 1'b0;
    end
  end

  // Frame counter and sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i) begin
      r_frame_cnt <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_frame_done)        r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop_set)          r_ovf       <= 1'b1;
      else if (overflow_clr_i) r_ovf       <= 1'b0;
    end
  end

  // Saturating bit-error counter; clear beats a simultaneous increment.
  always_ff @(posedge sysclk_i) begin
    if (!rst_n_i)                             r_biterr <= '0;
    else if (biterr_clr_i)                    r_biterr <= '0;
    else if (dout_biterr_i && !(&r_biterr))   r_biterr <= r_biterr + ERRCNT_BITS'(1);
  end

  assign m_axis_tdata_o  = r_tdata;
  assign m_axis_tvalid_o = r_tvalid;
  assign m_axis_tlast_o  = r_tlast;
  assign frame_count_o   = r_frame_cnt;
  assign overflow_o      = r_ovf;
  assign biterr_count_o  = r_biterr;

endmodule
